// File: rtl/issue_queue_age_if.sv
// Issue queue bus bundle: dispatch lanes, wakeup lanes, issue ports, flush and occupancy.
//   master: dispatch/execute side (drives ops, wakeups, flush, out_ready)
//   slave : issue queue (drives in_ready, out_valid, out_data, count)
// Vectors are lane-major flat packings: lane l occupies bits [l*W +: W].
interface issue_queue_age_if #(
  parameter int unsigned RWD  = 4,
  parameter int unsigned IWD  = 4,
  parameter int unsigned EWD  = 4,
  parameter int unsigned IQSZ = 16,
  parameter int unsigned NSRC = 2,
  parameter int unsigned NFU  = 5,
  parameter int unsigned PW   = 16,
  parameter int unsigned DW   = 128
);
  localparam int unsigned CW = $clog2(IQSZ + 1);

  logic                   flush;
  logic [RWD-1:0]         in_valid;
  logic [RWD-1:0]         in_ready;
  logic [RWD*DW-1:0]      in_data;
  logic [RWD*NFU-1:0]     in_fu;
  logic [RWD*NSRC*PW-1:0] in_prs;
  logic [RWD*NSRC-1:0]    in_busy;
  logic [EWD-1:0]         wake_valid;
  logic [EWD*PW-1:0]      wake_prd;
  logic [IWD-1:0]         out_valid;
  logic [IWD-1:0]         out_ready;
  logic [IWD*DW-1:0]      out_data;
  logic [CW-1:0]          count;

  modport master (
    output flush, in_valid, in_data, in_fu, in_prs, in_busy, wake_valid, wake_prd, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_fu, in_prs, in_busy, wake_valid, wake_prd, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/issue_queue_age.sv
// Out-of-order issue queue with age-matrix oldest-first select and per-port FU binding.
//   clk   : clock
//   rst_n : asynchronous active-low reset, drops every entry
//   iq    : slave side of issue_queue_age_if (dispatch, wakeup, issue, flush, count)
// Entries wait until all source tags are woken, then each issue port in index order takes the
// oldest ready entry whose FU mask overlaps that port's PORT_FU mask.
module issue_queue_age #(
  parameter int unsigned RWD  = 4,
  parameter int unsigned IWD  = 4,
  parameter int unsigned EWD  = 4,
  parameter int unsigned IQSZ = 16,
  parameter int unsigned NSRC = 2,
  parameter int unsigned NFU  = 5,
  parameter int unsigned PW   = 16,
  parameter int unsigned DW   = 128,
  parameter logic [IWD-1:0][NFU-1:0] PORT_FU = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  issue_queue_age_if.slave iq
);
  localparam int unsigned CW = $clog2(IQSZ + 1);
  localparam int unsigned LW = (RWD > 1) ? $clog2(RWD) : 1;

  logic [IQSZ-1:0]                     valid_q, valid_d;
  logic [IQSZ-1:0][NSRC-1:0]           busy_q, busy_d;
  logic [IQSZ-1:0][NSRC-1:0][PW-1:0]   prs_q, prs_d;
  logic [IQSZ-1:0][NFU-1:0]            fu_q, fu_d;
  logic [IQSZ-1:0][DW-1:0]             data_q, data_d;
  // age_q[i][k] = 1: entry i is older than entry k
  logic [IQSZ-1:0][IQSZ-1:0]           age_q, age_d;
  logic [CW-1:0]                       count_q, count_d;

  logic [RWD-1:0][DW-1:0]              lane_data;
  logic [RWD-1:0][NFU-1:0]             lane_fu;
  logic [RWD-1:0][NSRC-1:0][PW-1:0]    lane_prs;
  logic [RWD-1:0][NSRC-1:0]            lane_busy;
  logic [EWD-1:0][PW-1:0]              wake_prd;

  logic [IQSZ-1:0][NSRC-1:0]           busy_eff;
  logic [IQSZ-1:0]                     rdy, taken, deq, keep, wr;
  logic [IWD-1:0][IQSZ-1:0]            cand, sel;
  logic                                older;
  logic [IWD-1:0]                      out_valid;
  logic [IWD-1:0][DW-1:0]              out_data;
  logic [RWD-1:0]                      in_ready;
  logic                                stop;
  int unsigned                         free, nacc, rank;
  logic [IQSZ-1:0][LW-1:0]             wr_lane;

  assign lane_data = iq.in_data;
  assign lane_fu   = iq.in_fu;
  assign lane_prs  = iq.in_prs;
  assign wake_prd  = iq.wake_prd;

  assign iq.in_ready  = in_ready;
  assign iq.out_valid = out_valid;
  assign iq.out_data  = out_data;
  assign iq.count     = count_q;

  function automatic logic tag_woken(input logic [PW-1:0] tag, input logic [EWD-1:0] wv,
                                     input logic [EWD-1:0][PW-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < EWD; j++) begin
      if (wv[j] && (wp[j] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Same-cycle wakeup forwarding for both resident and incoming operands.
  always_comb begin
    lane_busy = '0;
    busy_eff  = '0;
    rdy       = '0;
    for (int l = 0; l < RWD; l++) begin
      for (int s = 0; s < NSRC; s++) begin
        lane_busy[l][s] = iq.in_busy[l*NSRC+s] &
                          ~tag_woken(lane_prs[l][s], iq.wake_valid, wake_prd);
      end
    end
    for (int e = 0; e < IQSZ; e++) begin
      for (int s = 0; s < NSRC; s++) begin
        busy_eff[e][s] = busy_q[e][s] & ~tag_woken(prs_q[e][s], iq.wake_valid, wake_prd);
      end
      rdy[e] = valid_q[e] & ~(|busy_eff[e]) & ~iq.flush;
    end
  end

  // Ports pick in index order; an entry taken by a lower port is masked for higher ports.
  always_comb begin
    taken     = '0;
    cand      = '0;
    sel       = '0;
    deq       = '0;
    older     = 1'b0;
    out_valid = '0;
    out_data  = '0;
    for (int p = 0; p < IWD; p++) begin
      for (int e = 0; e < IQSZ; e++) begin
        cand[p][e] = rdy[e] & ~taken[e] & (|(fu_q[e] & PORT_FU[p]));
      end
      for (int e = 0; e < IQSZ; e++) begin
        older = 1'b0;
        for (int k = 0; k < IQSZ; k++) begin
          if (cand[p][k] && age_q[k][e]) older = 1'b1;
        end
        sel[p][e] = cand[p][e] & ~older;
      end
      taken        = taken | sel[p];
      out_valid[p] = |sel[p];
      for (int e = 0; e < IQSZ; e++) begin
        if (sel[p][e]) begin
          out_data[p] = out_data[p] | data_q[e];
          deq[e]      = deq[e] | iq.out_ready[p];
        end
      end
    end
  end

  // In-order prefix acceptance bounded by free slots at the start of the cycle.
  always_comb begin
    in_ready = '0;
    nacc     = 0;
    stop     = 1'b0;
    free     = IQSZ - 32'(count_q);
    for (int i = 0; i < RWD; i++) begin
      if (!stop && rst_n && !iq.flush && iq.in_valid[i] && (nacc < free)) begin
        in_ready[i] = 1'b1;
        nacc        = nacc + 1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Accepted lane n lands in the n-th lowest free slot.
  always_comb begin
    wr      = '0;
    wr_lane = '0;
    rank    = 0;
    for (int e = 0; e < IQSZ; e++) begin
      if (!valid_q[e]) begin
        if (rank < nacc) begin
          wr[e]      = 1'b1;
          wr_lane[e] = LW'(rank);
        end
        rank = rank + 1;
      end
    end
  end

  always_comb begin
    keep    = valid_q & ~deq;
    valid_d = keep | wr;
    busy_d  = busy_eff;
    prs_d   = prs_q;
    fu_d    = fu_q;
    data_d  = data_q;
    age_d   = '0;
    for (int e = 0; e < IQSZ; e++) begin
      if (wr[e]) begin
        busy_d[e] = lane_busy[wr_lane[e]];
        prs_d[e]  = lane_prs[wr_lane[e]];
        fu_d[e]   = lane_fu[wr_lane[e]];
        data_d[e] = lane_data[wr_lane[e]];
      end
    end
    // New entries are younger than all survivors; same-cycle writes order by lane.
    for (int i = 0; i < IQSZ; i++) begin
      for (int k = 0; k < IQSZ; k++) begin
        if (wr[i] && wr[k])  age_d[i][k] = (wr_lane[i] < wr_lane[k]);
        else if (wr[k])      age_d[i][k] = keep[i];
        else if (wr[i])      age_d[i][k] = 1'b0;
        else                 age_d[i][k] = age_q[i][k] & keep[i] & keep[k];
      end
    end
    if (iq.flush) begin
      valid_d = '0;
      age_d   = '0;
    end
    count_d = CW'($countones(valid_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      busy_q  <= '0;
      prs_q   <= '0;
      fu_q    <= '0;
      data_q  <= '0;
      age_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      prs_q   <= prs_d;
      fu_q    <= fu_d;
      data_q  <= data_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_issue_queue_age.sv
// Randomised + directed bench for issue_queue_age. The reference model is an age-ordered list of
// ops; per-cycle expectations go into scoreboard queues that a negedge monitor drains.
module tb_issue_queue_age;
  localparam int unsigned RWD = 4, IWD = 4, EWD = 4, IQSZ = 16;
  localparam int unsigned NSRC = 2, NFU = 5, PW = 16, DW = 128;
  // Port 0 takes ALU (class 0) only; ports 1..3 take every class.
  localparam logic [IWD-1:0][NFU-1:0] PFU = {5'h1F, 5'h1F, 5'h1F, 5'h01};

  typedef struct packed {
    logic [DW-1:0]             data;
    logic [NFU-1:0]            fu;
    logic [NSRC-1:0][PW-1:0]   prs;
    logic [NSRC-1:0]           busy;
  } op_t;
  typedef struct packed {
    logic [RWD-1:0] ir;
    logic [IWD-1:0] ov;
    logic [31:0]    cnt;
    logic           rst;
  } cyc_t;
  typedef struct packed {
    logic [31:0]   port;
    logic [DW-1:0] data;
  } iss_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_queue_age_if #(.RWD(RWD), .IWD(IWD), .EWD(EWD), .IQSZ(IQSZ), .NSRC(NSRC), .NFU(NFU),
                       .PW(PW), .DW(DW)) iq ();

  issue_queue_age #(.RWD(RWD), .IWD(IWD), .EWD(EWD), .IQSZ(IQSZ), .NSRC(NSRC), .NFU(NFU),
                    .PW(PW), .DW(DW), .PORT_FU(PFU)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq)
  );

  logic [RWD-1:0]                    in_v;
  logic [RWD-1:0][DW-1:0]            in_d;
  logic [RWD-1:0][NFU-1:0]           in_f;
  logic [RWD-1:0][NSRC-1:0][PW-1:0]  in_t;
  logic [RWD-1:0][NSRC-1:0]          in_b;
  logic [EWD-1:0]                    wk_v;
  logic [EWD-1:0][PW-1:0]            wk_t;
  logic [IWD-1:0]                    o_rdy;
  logic                              fl;
  logic [31:0]                       id = 32'd1;

  op_t  mq[$];
  cyc_t cyc_q[$];
  iss_t iss_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit woken(input logic [PW-1:0] t);
    for (int j = 0; j < EWD; j++) if (wk_v[j] && wk_t[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit op_ready(input op_t o);
    for (int s = 0; s < NSRC; s++) if (o.busy[s] && !woken(o.prs[s])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle();
    in_v = '0; in_d = '0; in_f = '0; in_t = '0; in_b = '0;
    wk_v = '0; wk_t = '0; o_rdy = '1; fl = 1'b0;
  endtask

  task automatic set_op(input int l, input logic [NFU-1:0] fu, input logic [PW-1:0] t0,
                        input logic b0, input logic [PW-1:0] t1, input logic b1);
    in_v[l] = 1'b1;
    in_f[l] = fu;
    in_t[l][0] = t0; in_b[l][0] = b0;
    in_t[l][1] = t1; in_b[l][1] = b1;
    in_d[l] = {$urandom(), $urandom(), $urandom(), id};
    id = id + 1;
  endtask

  // One clock: drive inputs after the edge, push expectations, advance the model.
  task automatic tick(input bit rst_pulse);
    cyc_t            rec;
    iss_t            is;
    op_t             nq[$];
    op_t             o;
    logic [IQSZ-1:0] pick, dq;
    int              acc, cnt;
    @(posedge clk);
    #1;
    iq.flush = fl; iq.in_valid = in_v; iq.in_data = in_d; iq.in_fu = in_f;
    iq.in_prs = in_t; iq.in_busy = in_b; iq.wake_valid = wk_v; iq.wake_prd = wk_t;
    iq.out_ready = o_rdy;
    rst_n = !rst_pulse;
    if (rst_pulse) mq.delete();
    cnt = mq.size();
    rec = '0;
    rec.cnt = cnt;
    rec.rst = rst_pulse;
    if (!rst_pulse && !fl) begin
      acc = 0;
      for (int i = 0; i < RWD; i++) begin
        if (!in_v[i] || acc >= int'(IQSZ) - cnt) break;
        rec.ir[i] = 1'b1;
        acc++;
      end
    end
    pick = '0;
    dq = '0;
    if (!rst_pulse && !fl) begin
      for (int p = 0; p < IWD; p++) begin
        for (int idx = 0; idx < mq.size(); idx++) begin
          if (!pick[idx] && (mq[idx].fu & PFU[p]) != '0 && op_ready(mq[idx])) begin
            pick[idx] = 1'b1;
            rec.ov[p] = 1'b1;
            is.port = 32'(p);
            is.data = mq[idx].data;
            iss_q.push_back(is);
            if (o_rdy[p]) dq[idx] = 1'b1;
            break;
          end
        end
      end
    end
    cyc_q.push_back(rec);
    if (fl) begin
      mq.delete();
    end else if (!rst_pulse) begin
      for (int idx = 0; idx < mq.size(); idx++) begin
        if (!dq[idx]) begin
          o = mq[idx];
          for (int s = 0; s < NSRC; s++) if (woken(o.prs[s])) o.busy[s] = 1'b0;
          nq.push_back(o);
        end
      end
      for (int i = 0; i < RWD; i++) begin
        if (rec.ir[i]) begin
          o.data = in_d[i];
          o.fu   = in_f[i];
          o.prs  = in_t[i];
          for (int s = 0; s < NSRC; s++) o.busy[s] = in_b[i][s] && !woken(in_t[i][s]);
          nq.push_back(o);
        end
      end
      mq = nq;
    end
  endtask

  // Monitor: compares the DUT against queued expectations half a cycle after the drive.
  initial begin
    cyc_t r;
    iss_t s;
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        r = cyc_q.pop_front();
        chk("in_ready", 512'(iq.in_ready), 512'(r.ir));
        chk("out_valid", 512'(iq.out_valid), 512'(r.ov));
        chk("count", 512'(iq.count), 512'(r.cnt));
        if (r.rst) chk("out_data_in_reset", 512'(iq.out_data), 512'(0));
        for (int p = 0; p < IWD; p++) begin
          if (iq.out_valid[p]) begin
            if (iss_q.size() == 0) begin
              chk("unexpected_issue_port", 512'(p), 512'(IWD));
            end else begin
              s = iss_q.pop_front();
              chk("issue_port", 512'(p), 512'(s.port));
              chk("issue_data", 512'(iq.out_data[p*DW +: DW]), 512'(s.data));
            end
          end
        end
      end
    end
  end

  initial begin
    idle();
    iq.flush = 1'b0; iq.in_valid = '0; iq.in_data = '0; iq.in_fu = '0; iq.in_prs = '0;
    iq.in_busy = '0; iq.wake_valid = '0; iq.wake_prd = '0; iq.out_ready = '0;
    // Reset: lanes valid but nothing may be accepted.
    in_v = '1;
    tick(1); tick(1);
    idle(); tick(0);

    // Four ready ALU ops, all four ports busy next cycle, oldest on port 0.
    for (int l = 0; l < RWD; l++) set_op(l, 5'h01, 16'd0, 1'b0, 16'd0, 1'b0);
    tick(0);
    idle(); tick(0);

    // Fill with busy MEM ops, full blocks dispatch, one wake frees a slot.
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int l = 0; l < RWD; l++) set_op(l, 5'h02, 16'(200 + 4*c + l), 1'b1, 16'd0, 1'b0);
      tick(0);
    end
    idle();
    for (int l = 0; l < RWD; l++) set_op(l, 5'h02, 16'd300, 1'b1, 16'd0, 1'b0);
    tick(0);
    wk_v[0] = 1'b1; wk_t[0] = 16'd203;
    tick(0);
    wk_v = '0;
    tick(0);
    idle(); fl = 1'b1; tick(0);
    idle(); tick(0);

    // Older op woken the same cycle beats a younger already-ready op.
    set_op(0, 5'h01, 16'd7, 1'b1, 16'd0, 1'b0);
    set_op(1, 5'h01, 16'd9, 1'b0, 16'd0, 1'b0);
    tick(0);
    idle(); wk_v[0] = 1'b1; wk_t[0] = 16'd7; tick(0);
    idle(); tick(0);

    // MEM op bypasses ALU-only port 0.
    set_op(0, 5'h02, 16'd1, 1'b0, 16'd2, 1'b0);
    tick(0);
    idle(); tick(0); tick(0);

    // Back-pressure on port 0 holds the op.
    set_op(0, 5'h01, 16'd3, 1'b0, 16'd4, 1'b0);
    tick(0);
    idle(); o_rdy = 4'b1110;
    tick(0); tick(0); tick(0);
    o_rdy = '1; tick(0); tick(0);

    // Flush with 10 residents and 2 dispatching, then reset mid-issue.
    for (int c = 0; c < 3; c++) begin
      idle();
      for (int l = 0; l < RWD; l++) if (4*c + l < 10) set_op(l, 5'h04, 16'd500, 1'b1, 16'd0, 1'b0);
      tick(0);
    end
    idle(); set_op(0, 5'h01, 16'd0, 1'b0, 16'd0, 1'b0); set_op(1, 5'h01, 16'd0, 1'b0, 16'd0, 1'b0);
    fl = 1'b1; tick(0);
    idle(); tick(0);
    for (int l = 0; l < RWD; l++) set_op(l, 5'h01, 16'd0, 1'b0, 16'd0, 1'b0);
    tick(0);
    idle(); tick(1);
    idle(); tick(0); tick(0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      idle();
      for (int l = 0; l < RWD; l++) begin
        if ($urandom_range(0, 4) != 0) begin
          set_op(l, 5'(1 << $urandom_range(0, 4)), 16'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) in_f[l] = 5'($urandom_range(1, 31));
        end
      end
      for (int j = 0; j < EWD; j++) begin
        wk_v[j] = 1'($urandom_range(0, 1));
        wk_t[j] = 16'($urandom_range(0, 15));
      end
      for (int p = 0; p < IWD; p++) o_rdy[p] = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 59) == 0);
      tick($urandom_range(0, 249) == 0);
    end

    idle(); tick(0); tick(0);
    repeat (2) @(posedge clk);
    #1;
    chk("cycle_records_drained", 512'(cyc_q.size()), 512'(0));
    chk("issue_records_drained", 512'(iss_q.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
